// File: rtl/of_alu_pkg.sv
// of_alu_pkg: OF->ALU payload layout and default field widths.
package of_alu_pkg;
    localparam int OF_DATA_W    = 32;
    localparam int OF_ALU_SIG_W = 13;
    localparam int OF_REG_W     = 5;
    localparam int OF_CNT_W     = 16;

    // Field order here is the packing order used on the skid buffer's flat vector.
    typedef struct packed {
        logic [OF_DATA_W-1:0]    op1;
        logic [OF_DATA_W-1:0]    op2;
        logic [OF_ALU_SIG_W-1:0] aluSignals;
        logic [OF_REG_W-1:0]     rd;
        logic                    isWb;
        logic [OF_REG_W-1:0]     rs1;
        logic [OF_REG_W-1:0]     rs2;
    } of_alu_bundle_t;

    localparam int BUNDLE_W = $bits(of_alu_bundle_t);
endpackage

// File: rtl/of_alu_pipe_skid_buf.sv
// pipe_skid_buf: 2-slot FIFO-ordered skid buffer with registered in_ready and sync flush.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_fire, load;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    // main slot can take a new entry when empty or draining this cycle
    assign load      = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = flush ? 1'b0 : (load ? (skid_valid_q || in_fire) : 1'b1);
        skid_valid_d = flush ? 1'b0 : (load ? 1'b0 : (skid_valid_q || in_fire));
        main_d       = !load ? main_q : (skid_valid_q ? skid_q : (in_fire ? in_data : main_q));
        skid_d       = (!load && in_fire) ? in_data : skid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end
endmodule

// File: rtl/of_alu_pipe_skid.sv
// of_alu_pipe_skid: OF->ALU pipeline register with skid buffer, flush and saturating stall counter.
module of_alu_pipe_skid
    import of_alu_pkg::*;
#(
    parameter int DATA_W    = OF_DATA_W,
    parameter int ALU_SIG_W = OF_ALU_SIG_W,
    parameter int REG_W     = OF_REG_W,
    parameter int CNT_W     = OF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    op1_OF,
    input  logic [DATA_W-1:0]    op2_OF,
    input  logic [ALU_SIG_W-1:0] aluSignals_OF,
    input  logic [REG_W-1:0]     rd_OF,
    input  logic                 isWb_OF,
    input  logic [REG_W-1:0]     rs1_OF,
    input  logic [REG_W-1:0]     rs2_OF,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    op1_ALU,
    output logic [DATA_W-1:0]    op2_ALU,
    output logic [ALU_SIG_W-1:0] aluSignals_ALU,
    output logic [REG_W-1:0]     rd_ALU,
    output logic                 isWb_ALU,
    output logic [REG_W-1:0]     rs1_ALU,
    output logic [REG_W-1:0]     rs2_ALU,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int BW = 2 * DATA_W + ALU_SIG_W + 3 * REG_W + 1;

    logic [BW-1:0]    in_data, out_data;
    logic             main_isWb;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // same field order as of_alu_bundle_t
    assign in_data = {op1_OF, op2_OF, aluSignals_OF, rd_OF, isWb_OF, rs1_OF, rs2_OF};
    assign {op1_ALU, op2_ALU, aluSignals_ALU, rd_ALU, main_isWb, rs1_ALU, rs2_ALU} = out_data;
    assign isWb_ALU  = main_isWb && out_valid;
    assign stall_cnt = stall_cnt_q;

    pipe_skid_buf #(.WIDTH(BW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always_comb begin
        stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
endmodule

// File: tb/tb_of_alu_pipe_skid.sv
// tb_of_alu_pipe_skid: directed checks of handshake, skid ordering, flush, stall counter and reset.
module tb_of_alu_pipe_skid;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] op1_OF = '0, op2_OF = '0;
    logic [12:0] aluSignals_OF = '0;
    logic [4:0]  rd_OF = '0, rs1_OF = '0, rs2_OF = '0;
    logic        isWb_OF = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] op1_ALU, op2_ALU;
    logic [12:0] aluSignals_ALU;
    logic [4:0]  rd_ALU, rs1_ALU, rs2_ALU;
    logic        isWb_ALU;
    logic        flush = 1'b0;
    logic [3:0]  stall_cnt;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    of_alu_pipe_skid #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1_OF(op1_OF), .op2_OF(op2_OF), .aluSignals_OF(aluSignals_OF), .rd_OF(rd_OF),
        .isWb_OF(isWb_OF), .rs1_OF(rs1_OF), .rs2_OF(rs2_OF),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1_ALU(op1_ALU), .op2_ALU(op2_ALU), .aluSignals_ALU(aluSignals_ALU), .rd_ALU(rd_ALU),
        .isWb_ALU(isWb_ALU), .rs1_ALU(rs1_ALU), .rs2_ALU(rs2_ALU),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] op1, input logic wb);
        in_valid = 1'b1;
        op1_OF   = op1;
        isWb_OF  = wb;
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_op1", 64'(op1_ALU), 64'd0);
        // streaming at full rate
        out_ready = 1'b1;
        send(32'd1, 1'b0);
        step();
        chk("stream_op1_1", 64'(op1_ALU), 64'd1);
        chk("stream_valid_1", 64'(out_valid), 64'd1);
        send(32'd2, 1'b0);
        step();
        chk("stream_op1_2", 64'(op1_ALU), 64'd2);
        chk("stream_ready_2", 64'(in_ready), 64'd1);
        send(32'd3, 1'b0);
        step();
        chk("stream_op1_3", 64'(op1_ALU), 64'd3);
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(out_valid), 64'd0);
        chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
        // back-pressure: A in main, B into skid
        out_ready = 1'b0;
        send(32'hA, 1'b0);
        step();
        chk("bp_A_main", 64'(op1_ALU), 64'hA);
        send(32'hB, 1'b0);
        step();
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_A", 64'(op1_ALU), 64'hA);
        chk("bp_stall_cnt_1", 64'(stall_cnt), 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_hold_A2", 64'(op1_ALU), 64'hA);
        chk("bp_stall_cnt_2", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_B_main", 64'(op1_ALU), 64'hB);
        chk("bp_B_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);
        // flush with main=A(isWb), skid=B and C offered
        out_ready = 1'b0;
        send(32'h11, 1'b1);
        step();
        chk("fl_isWb_A", 64'(isWb_ALU), 64'd1);
        send(32'h22, 1'b0);
        step();
        chk("fl_skid_full", 64'(in_ready), 64'd0);
        send(32'h33, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_isWb", 64'(isWb_ALU), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt), 64'd4);
        out_ready = 1'b1;
        step();
        chk("fl_no_C", 64'(out_valid), 64'd0);
        // flush beats a real in_fire into an empty stage
        send(32'h44, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_infire_dropped", 64'(out_valid), 64'd0);
        step();
        chk("fl_infire_gone", 64'(out_valid), 64'd0);
        // stall counter saturation
        out_ready = 1'b0;
        send(32'h55, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_after_flush", 64'(stall_cnt), 64'd15);
        chk("sat_flush_valid", 64'(out_valid), 64'd0);
        // forwarding fields travel with operands and stay stable in a stall
        send(32'hDEAD, 1'b1);
        op2_OF = 32'hBEEF;
        rs1_OF = 5'd5;
        rs2_OF = 5'd31;
        rd_OF = 5'd7;
        aluSignals_OF = 13'h1ABC;
        step();
        in_valid = 1'b0;
        op1_OF = '0;
        op2_OF = '1;
        rs1_OF = 5'd1;
        rs2_OF = 5'd2;
        rd_OF = 5'd3;
        aluSignals_OF = 13'h0001;
        for (int i = 0; i < 4; i++) begin
            chk("fwd_op1", 64'(op1_ALU), 64'hDEAD);
            chk("fwd_op2", 64'(op2_ALU), 64'hBEEF);
            chk("fwd_rs1", 64'(rs1_ALU), 64'd5);
            chk("fwd_rs2", 64'(rs2_ALU), 64'd31);
            chk("fwd_rd", 64'(rd_ALU), 64'd7);
            chk("fwd_alu", 64'(aluSignals_ALU), 64'h1ABC);
            chk("fwd_isWb", 64'(isWb_ALU), 64'd1);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step();
        chk("fwd_drained", 64'(out_valid), 64'd0);
        // asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        send(32'h1234, 1'b1);
        rd_OF = 5'd9;
        step();
        in_valid = 1'b0;
        chk("mid_valid_before", 64'(out_valid), 64'd1);
        chk("mid_op1_before", 64'(op1_ALU), 64'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_op1", 64'(op1_ALU), 64'd0);
        chk("mid_rd", 64'(rd_ALU), 64'd0);
        chk("mid_isWb", 64'(isWb_ALU), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_stays_empty", 64'(out_valid), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
